// File: rtl/serial_adder_pkg.sv
// Shared types for the bit-serial add/subtract controller.
//   state_t : controller FSM states (IDLE, RUN, DONE), fixed encodings below.
package serial_adder_pkg;

  localparam logic [1:0] EncIdle = 2'd0;
  localparam logic [1:0] EncRun  = 2'd1;
  localparam logic [1:0] EncDone = 2'd2;

  typedef enum logic [1:0] {
    IDLE = EncIdle,
    RUN  = EncRun,
    DONE = EncDone
  } state_t;

endpackage

// File: rtl/full_adder.sv
// Single-bit full adder cell.
//   in0, in1, in2 : addend bits (in2 is normally the carry-in)
//   sum           : in0 ^ in1 ^ in2
//   carry         : majority of the three inputs
module full_adder (
  input  logic in0,
  input  logic in1,
  input  logic in2,
  output logic sum,
  output logic carry
);

  assign sum   = in0 ^ in1 ^ in2;
  assign carry = (in0 & in1) | (in2 & (in0 ^ in1));

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial add/subtract controller. One full_adder cell is reused for WIDTH cycles, LSB first.
//   clk, rst_n : clock, asynchronous active-low reset
//   start      : begin an operation (accepted in IDLE or DONE only)
//   sub        : 0 = a + b + cin, 1 = a - b
//   a, b, cin  : operands, sampled together with start
//   busy       : high while bits are being processed
//   done       : one-cycle pulse when sum/cout/ovf have been updated
//   sum        : result, held until the next completion
//   cout       : final carry (for subtraction 1 = no borrow)
//   ovf        : signed overflow
module serial_adder_ctrl
  import serial_adder_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int unsigned CntW = $clog2(WIDTH);
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

  state_t           state_q;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] sum_sh;
  logic             carry_q;
  logic [CntW-1:0]  cnt;

  logic fa_sum;
  logic fa_carry;

  full_adder u_full_adder (
    .in0   (a_sh[0]),
    .in1   (b_sh[0]),
    .in2   (carry_q),
    .sum   (fa_sum),
    .carry (fa_carry)
  );

  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_sh    <= '0;
      b_sh    <= '0;
      sum_sh  <= '0;
      carry_q <= 1'b0;
      cnt     <= '0;
      sum     <= '0;
      cout    <= 1'b0;
      ovf     <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE, DONE: begin
          if (start) begin
            // Subtraction is a + ~b + 1: invert b and force the initial carry.
            a_sh    <= a;
            b_sh    <= sub ? ~b : b;
            carry_q <= sub ? 1'b1 : cin;
            cnt     <= '0;
            state_q <= RUN;
          end else begin
            state_q <= IDLE;
          end
        end
        RUN: begin
          a_sh    <= a_sh >> 1;
          b_sh    <= b_sh >> 1;
          sum_sh  <= {fa_sum, sum_sh[WIDTH-1:1]};
          carry_q <= fa_carry;
          if (cnt == LastCnt) begin
            // carry_q here is the carry into the MSB, so overflow is it XOR carry-out.
            sum     <= {fa_sum, sum_sh[WIDTH-1:1]};
            cout    <= fa_carry;
            ovf     <= carry_q ^ fa_carry;
            cnt     <= '0;
            state_q <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
module tb_serial_adder_ctrl;

  localparam int unsigned W = 8;

  typedef struct packed {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
  } exp_t;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic         sub;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;

  int   checks   = 0;
  int   failures = 0;
  exp_t sb_q[$];
  logic [W-1:0] hold_sum = '0;

  serial_adder_ctrl #(
    .WIDTH (W)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .sub   (sub),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout),
    .ovf   (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain wide addition, overflow from operand/result sign bits.
  function automatic exp_t model(input logic [W-1:0] aa, input logic [W-1:0] bb,
                                 input logic cc, input logic ss);
    exp_t         e;
    logic [W-1:0] bx;
    logic [W:0]   r;
    bx     = ss ? ~bb : bb;
    r      = {1'b0, aa} + {1'b0, bx} + {{W{1'b0}}, (ss ? 1'b1 : cc)};
    e.sum  = r[W-1:0];
    e.cout = r[W];
    e.ovf  = (aa[W-1] == bx[W-1]) && (r[W-1] != aa[W-1]);
    return e;
  endfunction

  // Scoreboard consumer: every done pulse must match the oldest pending expectation.
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (sb_q.size() == 0) begin
        check_eq("spurious_done", {31'd0, done}, 32'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check_eq("sum", {24'd0, sum}, {24'd0, e.sum});
        check_eq("cout", {31'd0, cout}, {31'd0, e.cout});
        check_eq("ovf", {31'd0, ovf}, {31'd0, e.ovf});
        hold_sum = e.sum;
      end
    end
  end

  // Called at a negedge: present an operation and record its expected result.
  task automatic start_op(input logic [W-1:0] aa, input logic [W-1:0] bb,
                          input logic cc, input logic ss);
    a     = aa;
    b     = bb;
    cin   = cc;
    sub   = ss;
    start = 1'b1;
    sb_q.push_back(model(aa, bb, cc, ss));
  endtask

  // Counts negedges until done; optionally pokes start mid-run with other operands.
  task automatic wait_done(input int poke_at, output int n);
    n = 0;
    while (n < 40) begin
      @(negedge clk);
      n++;
      if (n == 1) begin
        start = 1'b0;
        check_eq("busy_first", {31'd0, busy}, 32'd1);
      end
      if (n == W) check_eq("sum_hold_run", {24'd0, sum}, {24'd0, hold_sum});
      if (poke_at != 0 && n == poke_at) begin
        start = 1'b1;
        a     = 8'hAA;
        b     = 8'h55;
        cin   = 1'b1;
      end
      if (poke_at != 0 && n == poke_at + 1) start = 1'b0;
      if (done) break;
    end
    if (!done) check_eq("timeout", 32'd0, 32'd1);
  endtask

  task automatic run_op(input logic [W-1:0] aa, input logic [W-1:0] bb,
                        input logic cc, input logic ss, input int poke_at);
    int n;
    @(negedge clk);
    start_op(aa, bb, cc, ss);
    wait_done(poke_at, n);
    check_eq("latency", n, W + 1);
  endtask

  initial begin
    int  n;
    bit  saw_done;
    rst_n = 1'b0;
    start = 1'b0;
    sub   = 1'b0;
    a     = '0;
    b     = '0;
    cin   = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_busy", {31'd0, busy}, 32'd0);
    check_eq("rst_done", {31'd0, done}, 32'd0);
    check_eq("rst_sum", {24'd0, sum}, 32'd0);
    check_eq("rst_cout", {31'd0, cout}, 32'd0);
    check_eq("rst_ovf", {31'd0, ovf}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    run_op(8'h00, 8'h00, 1'b0, 1'b0, 0);
    run_op(8'hFF, 8'h01, 1'b0, 1'b0, 0);
    run_op(8'hFF, 8'h01, 1'b1, 1'b0, 0);
    run_op(8'h7F, 8'h01, 1'b0, 1'b0, 0);
    run_op(8'h05, 8'h07, 1'b0, 1'b1, 0);
    run_op(8'h80, 8'h01, 1'b0, 1'b1, 0);
    // start during RUN must not disturb the operation in flight
    run_op(8'h11, 8'h22, 1'b0, 1'b0, 4);
    repeat (2) @(negedge clk);

    // Back-to-back: start held in the DONE cycle
    run_op(8'h3C, 8'h0F, 1'b1, 1'b0, 0);
    start_op(8'h40, 8'h40, 1'b0, 1'b0);
    wait_done(0, n);
    check_eq("b2b_gap", n, W + 1);
    repeat (2) @(negedge clk);

    // Asynchronous reset in the middle of a run
    start_op(8'h0F, 8'h01, 1'b0, 1'b0);
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_eq("mid_rst_busy", {31'd0, busy}, 32'd0);
    check_eq("mid_rst_done", {31'd0, done}, 32'd0);
    check_eq("mid_rst_sum", {24'd0, sum}, 32'd0);
    check_eq("mid_rst_cout", {31'd0, cout}, 32'd0);
    check_eq("mid_rst_ovf", {31'd0, ovf}, 32'd0);
    sb_q.delete();
    hold_sum = '0;
    @(negedge clk);
    rst_n    = 1'b1;
    saw_done = 1'b0;
    repeat (W + 3) begin
      @(negedge clk);
      if (done) saw_done = 1'b1;
    end
    check_eq("no_done_after_rst", {31'd0, saw_done}, 32'd0);

    run_op(8'h12, 8'h34, 1'b0, 1'b0, 0);
    repeat (3) @(negedge clk);
    check_eq("sb_empty", sb_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
